// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// Stream handshake: a byte moves on a rising edge where byte_valid && byte_ready are both high;
// the source holds byte_in stable while byte_valid is high and byte_ready is low.
interface im_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst_f;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rst_f, done, err, state_dbg
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rst_f, done, err, state_dbg
  );
endinterface

// File: rtl/im_loader.sv
// Boot-time program loader: header count, big-endian word assembly, sequential IM writes.
// Optional trailing XOR checksum byte when IM_LOADER_CKSUM_EN is defined.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          DEPTH     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  im_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
`ifdef IM_LOADER_CKSUM_EN
    S_CKSUM  = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // State entered once the last word is written (or the header count is zero).
`ifdef IM_LOADER_CKSUM_EN
  localparam state_t S_TAIL = S_CKSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  state_t      state_nxt;

  logic [15:0] count_q;
  logic [15:0] index_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;

  logic        accepting;
  logic        xfer;
  logic [15:0] full_count;
  logic        count_big;
  logic        count_zero;
  logic        last_word;
  logic        restart;
  logic        cksum_ok;

  // Ready is a function of state only, so it never depends on byte_valid.
  assign accepting = !rst && (state == S_HDR_HI || state == S_HDR_LO || state == S_DATA
`ifdef IM_LOADER_CKSUM_EN
                              || state == S_CKSUM
`endif
                              );

  assign xfer       = bus.byte_valid && accepting;
  assign full_count = {count_q[15:8], bus.byte_in};
  assign count_big  = {1'b0, full_count} > DEPTH_L;
  assign count_zero = (full_count == 16'd0);
  assign last_word  = ((index_q + 16'd1) == count_q);
  assign restart    = bus.start && (state == S_DONE || state == S_ERR);

`ifdef IM_LOADER_CKSUM_EN
  logic [7:0] xor_q;

  assign cksum_ok = (bus.byte_in == xor_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q <= 8'h00;
    end else if (restart) begin
      xor_q <= 8'h00;
    end else if (xfer) begin
      xor_q <= xor_q ^ bus.byte_in;
    end
  end
`else
  assign cksum_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.byte_ready = accepting;
    bus.im_we      = 1'b0;
    bus.im_addr    = addr_q;
    bus.im_wdata   = wdata_q;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.cpu_rst_f  = 1'b0;
    bus.state_dbg  = state;

    unique case (state)
      S_HDR_HI: begin
        if (xfer) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          if (count_big) begin
            state_nxt = S_ERR;
          end else if (count_zero) begin
            state_nxt = S_TAIL;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt_q == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        bus.im_we = !rst;
        state_nxt = last_word ? S_TAIL : S_DATA;
      end
`ifdef IM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (xfer) state_nxt = cksum_ok ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        bus.done      = 1'b1;
        bus.cpu_rst_f = 1'b1;
        if (bus.start) state_nxt = S_HDR_HI;
      end
      S_ERR: begin
        bus.err = 1'b1;
        if (bus.start) state_nxt = S_HDR_HI;
      end
      default: begin
        state_nxt = S_HDR_HI;
      end
    endcase
  end

  // Datapath: header count, word index, byte assembly and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 16'h0000;
      index_q    <= 16'h0000;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'h000000;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'h00000000;
    end else begin
      unique case (state)
        S_HDR_HI: begin
          if (xfer) count_q[15:8] <= bus.byte_in;
        end
        S_HDR_LO: begin
          if (xfer) begin
            count_q[7:0] <= bus.byte_in;
            index_q      <= 16'h0000;
            byte_cnt_q   <= 2'd0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {asm_q[15:0], bus.byte_in};
            if (byte_cnt_q == 2'd3) begin
              wdata_q <= {asm_q, bus.byte_in};
              addr_q  <= BASE_ADDR + index_q;
            end
          end
        end
        S_WRITE: begin
          index_q <= index_q + 16'd1;
        end
        S_DONE, S_ERR: begin
          if (bus.start) begin
            count_q    <= 16'h0000;
            index_q    <= 16'h0000;
            byte_cnt_q <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // cksum_ok is only consumed by the checksum state.
  logic unused_ok;
  assign unused_ok = cksum_ok;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed scenarios plus randomized images against an
// image-level model (expected write list, end status, end cycle).
`timescale 1ns/1ps
module tb_im_loader;
  localparam logic [15:0] BASE  = 16'h0000;
  localparam int          DEPTH = 1024;
`ifdef IM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im_loader_if bus ();

  im_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = -1;
  int last_we_cyc = -1;
  int prev_we_cyc = -1;
  bit gap_check = 1'b0;

  logic [47:0] exp_q[$];
  logic [31:0] img[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    chk("done_err_exclusive", 48'(bus.done && bus.err), 48'd0);
    chk("cpu_rst_f_tracks_done", 48'(bus.cpu_rst_f), 48'(bus.done));
    if (bus.im_we) begin
      chk("write_expected", 48'(exp_q.size() > 0), 48'd1);
      chk("write_latency", 48'(cyc), 48'(last_acc_cyc + 1));
      if (gap_check && prev_we_cyc >= 0) chk("write_gap", 48'(cyc - prev_we_cyc), 48'd5);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {bus.im_addr, bus.im_wdata}, e);
      end
      prev_we_cyc = cyc;
      last_we_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int idle);
    bit got = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (idle) @(posedge clk);
    #1;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.byte_ready) begin
        got = 1'b1;
        last_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    n_vec++;
    assert (got) else begin
      n_err++;
      $error("FAIL byte_accept_timeout: observed ready=0 expected ready=1 (byte %h)", b);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic restart();
    pulse_start();
    @(negedge clk);
    chk("restart_done", 48'(bus.done), 48'd0);
    chk("restart_err", 48'(bus.err), 48'd0);
    chk("restart_cpu_rst_f", 48'(bus.cpu_rst_f), 48'd0);
    chk("restart_ready", 48'(bus.byte_ready), 48'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input bit exp_err, input bit end_on_write);
    bit seen = 1'b0;
    int exp_cyc;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = bus.done || bus.err;
    end
    exp_cyc = end_on_write ? last_we_cyc + 1 : last_acc_cyc + 1;
    chk("end_seen", 48'(seen), 48'd1);
    chk("end_cycle", 48'(cyc), 48'(exp_cyc));
    chk("end_done", 48'(bus.done), 48'(!exp_err));
    chk("end_err", 48'(bus.err), 48'(exp_err));
    chk("end_cpu_rst_f", 48'(bus.cpu_rst_f), 48'(!exp_err));
    chk("end_ready", 48'(bus.byte_ready), 48'd0);
    chk("writes_drained", 48'(exp_q.size()), 48'd0);
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected writes, checksum and outcome derived from the image alone.
  task automatic load_image(input int count, input int idle_lo, input int idle_hi,
                            input bit bad_ck, input bit poke_start);
    logic [15:0] c16;
    logic [7:0]  x;
    logic [7:0]  b;
    bit          hdr_err;
    c16 = count[15:0];
    hdr_err = (count > DEPTH);
    x = c16[15:8] ^ c16[7:0];
    prev_we_cyc = -1;
    gap_check = (idle_hi == 0);
    if (!hdr_err) begin
      for (int i = 0; i < count; i++) exp_q.push_back({BASE + i[15:0], img[i]});
    end
    send_byte(c16[15:8], $urandom_range(idle_lo, idle_hi));
    send_byte(c16[7:0], $urandom_range(idle_lo, idle_hi));
    if (!hdr_err) begin
      if (poke_start) pulse_start();
      for (int i = 0; i < count; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = img[i][31 - 8*k -: 8];
          x = x ^ b;
          send_byte(b, $urandom_range(idle_lo, idle_hi));
        end
      end
      if (CK) send_byte(bad_ck ? (x ^ 8'h01) : x, $urandom_range(idle_lo, idle_hi));
    end
    wait_end(hdr_err || (CK && bad_ck), (count > 0) && !hdr_err && !CK);
    gap_check = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 48'(bus.byte_ready), 48'd0);
    chk("rst_we", 48'(bus.im_we), 48'd0);
    chk("rst_addr", 48'(bus.im_addr), 48'(BASE));
    chk("rst_wdata", 48'(bus.im_wdata), 48'd0);
    chk("rst_cpu_rst_f", 48'(bus.cpu_rst_f), 48'd0);
    chk("rst_done", 48'(bus.done), 48'd0);
    chk("rst_err", 48'(bus.err), 48'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 48'(bus.byte_ready), 48'd1);
    @(posedge clk);
    #1;

    // Two words at full rate, then the same image with 3 idle cycles between bytes.
    img = '{32'h11223344, 32'h55667788};
    load_image(2, 0, 0, 1'b0, 1'b0);
    restart();
    load_image(2, 3, 3, 1'b0, 1'b0);

    // Empty image, then the single-word checksum pair.
    restart();
    load_image(0, 0, 1, 1'b0, 1'b0);
    restart();
    load_image(0, 0, 1, 1'b1, 1'b0);
    img = '{32'hDEADBEEF};
    restart();
    load_image(1, 0, 0, 1'b0, 1'b0);
    restart();
    load_image(1, 0, 2, 1'b1, 1'b0);

    // Random images with random pacing; start poked mid-load must be ignored.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      restart();
      load_image(n, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Largest accepted image.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    restart();
    load_image(DEPTH, 0, 0, 1'b0, 1'b0);

    // Reset after two data bytes abandons the load with no write.
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_ready_now", 48'(bus.byte_ready), 48'd0);
    @(negedge clk);
    chk("midrst_we", 48'(bus.im_we), 48'd0);
    chk("midrst_addr", 48'(bus.im_addr), 48'(BASE));
    chk("midrst_wdata", 48'(bus.im_wdata), 48'd0);
    chk("midrst_cpu_rst_f", 48'(bus.cpu_rst_f), 48'd0);
    chk("midrst_done", 48'(bus.done), 48'd0);
    chk("midrst_err", 48'(bus.err), 48'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Oversized header 04 01 (1025 words) aborts without writes and stops accepting.
    load_image(DEPTH + 1, 0, 0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("err_hold_ready", 48'(bus.byte_ready), 48'd0);
      chk("err_hold_err", 48'(bus.err), 48'd1);
    end
    @(posedge clk);
    #1;

    // Recovery from ERR.
    img = '{32'h00000001};
    restart();
    load_image(1, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time program loader: the write-side counterpart of the SISC instruction memory, which the processor only ever reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at sequential addresses.
- Holds the processor in reset (active-low cpu_rst_f, matching sisc's rst_f) until the image is fully loaded.

Parameters:
- BASE_ADDR, 16'h0000, instruction-memory address of the first loaded word.
- DEPTH, 1024, maximum word count accepted; a larger header count is an error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts a load from DONE or ERR; ignored in other states.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- im_we  output  1  instruction-memory write enable; single-cycle pulse per word.
- im_addr  output  16  instruction-memory write address.
- im_wdata  output  32  instruction word to write.
- cpu_rst_f  output  1  processor reset, active-low; released only in DONE.
- done  output  1  load completed successfully.
- err  output  1  load aborted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State = HDR_HI; word count and word index cleared; byte counter and assembly register cleared.
  - Outputs: byte_ready=0 during reset, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst_f=0, done=0, err=0.
  - Reset mid-load abandons the load. Words already written stay in memory; no further writes occur.
- States: HDR_HI, HDR_LO, DATA, WRITE, (CKSUM), DONE, ERR.
- byte_ready=1 only in HDR_HI, HDR_LO, DATA and CKSUM. It is 0 in WRITE, DONE and ERR.
- HDR_HI: on a transfer, count[15:8]=byte_in; go to HDR_LO.
- HDR_LO: on a transfer, count[7:0]=byte_in. Then, using the complete count:
  - count > DEPTH: go to ERR.
  - count == 0: go to CKSUM if enabled, else DONE.
  - otherwise: go to DATA with word index 0.
- DATA:
  - Bytes arrive MSB first: 1st byte -> bits[31:24], then [23:16], [15:8], [7:0].
  - A 2-bit byte counter advances only on transfers; idle cycles (byte_valid=0) hold all state.
  - On the 4th transfer, load im_wdata, set im_addr = BASE_ADDR + index (16-bit wrap-around), and go to WRITE.
- WRITE: lasts exactly one cycle with im_we=1; im_addr and im_wdata are stable. On exit, index increments.
  - If index+1 == count: go to CKSUM if enabled, else DONE.
  - Otherwise: return to DATA.
- Write latency: im_we is asserted the cycle after the 4th byte of a word is accepted. Back-to-back words therefore cost 5 cycles each, because byte_ready=0 in WRITE.
- DONE: done=1, cpu_rst_f=1; held until start or rst.
- ERR: err=1, cpu_rst_f=0, no writes; held until start or rst.
- start in DONE or ERR, at the next edge:
  - state = HDR_HI; done=0, err=0, cpu_rst_f=0 (processor re-held in reset).
  - index, count and byte counter cleared.
- start in any other state has no effect. When rst and start are both asserted, rst wins.
- done and err are never high together. im_we is never high outside WRITE.

Optional Feature:
- Macro: IM_LOADER_CKSUM_EN.
- Defined:
  - A running XOR covers every accepted header and data byte.
  - After the last word (or straight after the header when count==0), the state machine enters CKSUM and accepts one byte.
  - Byte equals the running XOR: go to DONE. Otherwise: go to ERR.
  - The running XOR clears on rst and on start.
- Undefined: the CKSUM state and XOR register are absent; the last WRITE (or a zero count) goes directly to DONE.

Test Plan:
- Stream 00 02 | 11 22 33 44 | 55 66 77 88 with byte_valid held high, BASE_ADDR=0:
  - im_we pulses twice: (addr 0000, 11223344) and (addr 0001, 55667788).
  - Then done=1 and cpu_rst_f rises 1 cycle after the 2nd WRITE; err=0 throughout.
- Same stream with byte_valid deasserted for 3 cycles between every byte: identical writes and data; byte counter does not advance on idle cycles.
- Header 04 01 with DEPTH=1024 (count 1025): ERR the cycle after the 2nd byte; err=1, cpu_rst_f=0, no im_we; byte_ready=0 from then on.
- Header 00 00: done=1 with no writes. With IM_LOADER_CKSUM_EN, the trailing byte 00 gives done, and 01 gives err.
- With IM_LOADER_CKSUM_EN, stream 00 01 | DE AD BE EF:
  - Checksum byte 00^01^DE^AD^BE^EF = 0x23 gives done.
  - Checksum byte 0x24 gives err after the single write (addr 0000, DEADBEEF).
- Recovery and reset:
  - Assert rst after 2 data bytes: all outputs return to reset values and no write occurs.
  - Next, from ERR, pulse start and send 00 01 | 00 00 00 01: one write (0000, 00000001), done=1.
